// File: rtl/ocx_tlx_framer_param_fifo_pkg.sv
// Shared constants, depth-mode type and parameter sanity helpers for the
// parametrised framer command FIFO.
package ocx_tlx_framer_param_fifo_pkg;

   localparam int DEF_DATA_WIDTH   = 172;
   localparam int DEF_DEPTH        = 8;
   localparam int DEF_ADDR_WIDTH   = 3;
   localparam int DEF_AFULL_THRESH = 6;

   typedef enum logic {
      MODE_FULL_DEPTH = 1'b0,
      MODE_MIN_DEPTH  = 1'b1
   } depth_mode_e;

   function automatic bit is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

   function automatic bit params_ok(input int depth, input int addr_width, input int afull);
      return is_pow2(depth) && ((1 << addr_width) == depth) && (afull >= 1) && (afull <= depth);
   endfunction

endpackage

// File: rtl/ocx_tlx_framer_param_fifo_if.sv
// Command-side bus of the framer FIFO: producer/consumer controls plus
// status outputs. master = TLX command side, slave = the FIFO itself.
interface ocx_tlx_framer_param_fifo_if #(
   parameter int DATA_WIDTH = 172,
   parameter int ADDR_WIDTH = 3
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  wr_enable;
   logic                  rd_done;
   logic                  use_min_fifo_depth;
   logic                  error_clear;

   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_available;
   logic                  full;
   logic                  almost_full;
   logic [ADDR_WIDTH:0]   valid_entry_count;
   logic [ADDR_WIDTH:0]   high_water_mark;
   logic                  underflow_error;
   logic                  overflow_error;
   logic                  underflow_sticky;
   logic                  overflow_sticky;
   logic                  min_depth_active;

   modport master (
      output data_in, wr_enable, rd_done, use_min_fifo_depth, error_clear,
      input  data_out, data_available, full, almost_full, valid_entry_count,
             high_water_mark, underflow_error, overflow_error,
             underflow_sticky, overflow_sticky, min_depth_active
   );

   modport slave (
      input  data_in, wr_enable, rd_done, use_min_fifo_depth, error_clear,
      output data_out, data_available, full, almost_full, valid_entry_count,
             high_water_mark, underflow_error, overflow_error,
             underflow_sticky, overflow_sticky, min_depth_active
   );
endinterface

// File: rtl/ocx_tlx_framer_param_fifo_regfile.sv
// Storage for the framer FIFO: one synchronous write port, one asynchronous
// read port so the head entry falls through without latency.
module ocx_tlx_fifo_regfile #(
   parameter int DATA_WIDTH = 172,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clock,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   (* ram_style = "distributed" *)
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clock) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ocx_tlx_framer_param_fifo.sv
// First-word-fall-through command FIFO feeding the framer, with protected
// full/empty, almost-full backpressure, sticky errors, high-water mark and min-depth mode.
module ocx_tlx_framer_param_fifo
   import ocx_tlx_framer_param_fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int DEPTH        = DEF_DEPTH,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int AFULL_THRESH = DEF_AFULL_THRESH
) (
   input  logic                        clock,
   input  logic                        reset_n,
   ocx_tlx_framer_param_fifo_if.slave  bus
);

   localparam int CW = ADDR_WIDTH + 1;
   typedef logic [CW-1:0]         cnt_t;
   typedef logic [ADDR_WIDTH-1:0] ptr_t;

   localparam cnt_t CNTR_0     = '0;
   localparam cnt_t CNTR_1     = cnt_t'(1);
   localparam cnt_t CNTR_DEPTH = cnt_t'(DEPTH);
   localparam cnt_t CNTR_AFULL = cnt_t'(AFULL_THRESH);
   localparam ptr_t PTR_0      = '0;
   localparam ptr_t PTR_1      = ptr_t'(1);

   generate
      if (!params_ok(DEPTH, ADDR_WIDTH, AFULL_THRESH)) begin : g_param_err
         $error("ocx_tlx_framer_param_fifo: DEPTH must be a power of 2 >= 2 equal to 2**ADDR_WIDTH, AFULL_THRESH in 1..DEPTH");
      end
   endgenerate

   cnt_t        r_count;
   cnt_t        r_hwm;
   ptr_t        r_wr_ptr;
   ptr_t        r_rd_ptr;
   depth_mode_e r_mode;
   logic        r_underflow_sticky;
   logic        r_overflow_sticky;

   cnt_t                  w_eff;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic                  w_underflow;
   logic                  w_overflow;
   cnt_t                  w_count_nxt;
   cnt_t                  w_hwm_nxt;
   depth_mode_e           w_mode_nxt;
   ptr_t                  w_wr_ptr_nxt;
   ptr_t                  w_rd_ptr_nxt;
   logic [DATA_WIDTH-1:0] w_rd_data;

   assign w_eff    = (r_mode == MODE_MIN_DEPTH) ? CNTR_1 : CNTR_DEPTH;
   assign w_empty  = (r_count == CNTR_0);
   assign w_full   = (r_count == w_eff);
   assign w_rd_acc = bus.rd_done & ~w_empty;
   // A write into a full FIFO still lands when the head leaves in the same cycle.
   assign w_wr_acc = bus.wr_enable & ((r_count < w_eff) | w_rd_acc);

   assign w_underflow = bus.rd_done & w_empty;
   assign w_overflow  = bus.wr_enable & w_full & ~w_rd_acc;

   assign w_count_nxt = r_count + (w_wr_acc ? CNTR_1 : CNTR_0) - (w_rd_acc ? CNTR_1 : CNTR_0);
   assign w_hwm_nxt   = bus.error_clear ? w_count_nxt
                                        : ((w_count_nxt > r_hwm) ? w_count_nxt : r_hwm);

   // Mode only changes while idle and empty, so no live entry can be stranded.
   assign w_mode_nxt = (w_empty & ~w_wr_acc)
                       ? (bus.use_min_fifo_depth ? MODE_MIN_DEPTH : MODE_FULL_DEPTH)
                       : r_mode;

   assign w_wr_ptr_nxt = (w_mode_nxt == MODE_MIN_DEPTH) ? PTR_0
                                                        : r_wr_ptr + (w_wr_acc ? PTR_1 : PTR_0);
   assign w_rd_ptr_nxt = (w_mode_nxt == MODE_MIN_DEPTH) ? PTR_0
                                                        : r_rd_ptr + (w_rd_acc ? PTR_1 : PTR_0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count            <= CNTR_0;
         r_hwm              <= CNTR_0;
         r_wr_ptr           <= PTR_0;
         r_rd_ptr           <= PTR_0;
         r_mode             <= MODE_FULL_DEPTH;
         r_underflow_sticky <= 1'b0;
         r_overflow_sticky  <= 1'b0;
      end else begin
         r_count  <= w_count_nxt;
         r_hwm    <= w_hwm_nxt;
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_mode   <= w_mode_nxt;
         if (bus.error_clear) begin
            r_underflow_sticky <= 1'b0;
            r_overflow_sticky  <= 1'b0;
         end else begin
            r_underflow_sticky <= r_underflow_sticky | w_underflow;
            r_overflow_sticky  <= r_overflow_sticky  | w_overflow;
         end
      end
   end

   ocx_tlx_fifo_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_regfile (
      .clock     (clock),
      .i_wr_en   (w_wr_acc),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (bus.data_in),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data)
   );

   // Head is masked while empty so stale or unreset storage never leaks out.
   assign bus.data_out          = w_empty ? '0 : w_rd_data;
   assign bus.data_available    = ~w_empty;
   assign bus.full              = w_full;
   assign bus.almost_full       = (r_mode == MODE_MIN_DEPTH) ? w_full : (r_count >= CNTR_AFULL);
   assign bus.valid_entry_count = r_count;
   assign bus.high_water_mark   = r_hwm;
   assign bus.underflow_error   = w_underflow;
   assign bus.overflow_error    = w_overflow;
   assign bus.underflow_sticky  = r_underflow_sticky;
   assign bus.overflow_sticky   = r_overflow_sticky;
   assign bus.min_depth_active  = (r_mode == MODE_MIN_DEPTH);

endmodule
